// File: rtl/sm2cluster_rr_arb.sv
// sm2cluster_rr_arb: round-robin merge of NUM_IN SM request channels into one
// buffered L2 request stream, with per-input in-flight limits and tag-based
// routing of L2 responses back to the originating SM.

// Per-input in-flight request counter; o_avail drops once the limit is reached.
module sm2cluster_outst_cnt #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_avail
);
  logic [CNT_W-1:0] r_cnt;

  // Simultaneous inc/dec cancel; dec at zero is ignored so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= '0;
    else if (i_inc && !i_dec)               r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_avail = (r_cnt < CNT_W'(MAX_OUTST));
endmodule

module sm2cluster_rr_arb #(
  parameter int NUM_IN     = 4,
  parameter int SRC_W      = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512,
  parameter int MASK_W     = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTST  = 8,
  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 0,
  localparam int OSRC_W = SRC_W + IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             req_in_valid_i,
  output logic [NUM_IN-1:0]             req_in_ready_o,
  input  logic [NUM_IN-1:0][2:0]        req_in_opcode_i,
  input  logic [NUM_IN-1:0][2:0]        req_in_param_i,
  input  logic [NUM_IN-1:0][ADDR_W-1:0] req_in_addr_i,
  input  logic [NUM_IN-1:0][DATA_W-1:0] req_in_data_i,
  input  logic [NUM_IN-1:0][MASK_W-1:0] req_in_mask_i,
  input  logic [NUM_IN-1:0][SRC_W-1:0]  req_in_source_i,
  output logic                          req_out_valid_o,
  input  logic                          req_out_ready_i,
  output logic [2:0]                    req_out_opcode_o,
  output logic [2:0]                    req_out_param_o,
  output logic [ADDR_W-1:0]             req_out_addr_o,
  output logic [DATA_W-1:0]             req_out_data_o,
  output logic [MASK_W-1:0]             req_out_mask_o,
  output logic [OSRC_W-1:0]             req_out_source_o,
  input  logic                          rsp_in_valid_i,
  output logic                          rsp_in_ready_o,
  input  logic [2:0]                    rsp_in_opcode_i,
  input  logic [ADDR_W-1:0]             rsp_in_addr_i,
  input  logic [DATA_W-1:0]             rsp_in_data_i,
  input  logic [OSRC_W-1:0]             rsp_in_source_i,
  output logic [NUM_IN-1:0]             rsp_out_valid_o,
  input  logic [NUM_IN-1:0]             rsp_out_ready_i,
  output logic [NUM_IN-1:0][2:0]        rsp_out_opcode_o,
  output logic [NUM_IN-1:0][ADDR_W-1:0] rsp_out_addr_o,
  output logic [NUM_IN-1:0][DATA_W-1:0] rsp_out_data_o,
  output logic [NUM_IN-1:0][SRC_W-1:0]  rsp_out_source_o,
  output logic                          err_o
);
  localparam int PTR_W  = (IDX_W > 0) ? IDX_W : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic [OSRC_W-1:0] source;
  } req_t;

  logic [NUM_IN-1:0] w_avail, w_elig;
  logic [PTR_W-1:0]  r_ptr, w_gnt, w_rk;
  logic              w_gnt_vld, w_full, w_acc, w_rd, w_bad;
  logic [OSRC_W-1:0] w_wr_src;
  req_t              w_wr, w_rd_ent;
  req_t              r_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0] r_wp, r_rp;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_err;

  assign w_elig = req_in_valid_i & w_avail;

  // Round-robin scan starting just after the last accepted input.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int off = 1; off <= NUM_IN; off++) begin
      idx = (int'(r_ptr) + off) % NUM_IN;
      if (!w_gnt_vld && w_elig[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PTR_W'(idx);
      end
    end
  end

  assign w_full = (r_fcnt == FCNT_W'(FIFO_DEPTH));
  assign w_acc  = w_gnt_vld & ~w_full;

  // Only the granted input sees ready; held low throughout reset.
  always_comb begin
    req_in_ready_o = '0;
    if (w_gnt_vld && !w_full && !rst) req_in_ready_o[w_gnt] = 1'b1;
  end

  // Pointer advances only when the granted request is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= PTR_W'(NUM_IN - 1);
    else if (w_acc) r_ptr <= w_gnt;
  end

  // Outgoing tag carries the input index above the SM's own source tag;
  // returned responses are decoded from the same prefix.
  if (NUM_IN > 1) begin : g_idx
    assign w_wr_src = {w_gnt, req_in_source_i[w_gnt]};
    assign w_rk     = rsp_in_source_i[OSRC_W-1 -: IDX_W];
    assign w_bad    = ({1'b0, w_rk} >= (IDX_W+1)'(NUM_IN));
  end else begin : g_one
    assign w_wr_src = req_in_source_i[0];
    assign w_rk     = '0;
    assign w_bad    = 1'b0;
  end

  // Assemble the FIFO write entry from the granted channel.
  always_comb begin
    w_wr        = '0;
    w_wr.opcode = req_in_opcode_i[w_gnt];
    w_wr.param  = req_in_param_i[w_gnt];
    w_wr.addr   = req_in_addr_i[w_gnt];
    w_wr.mask   = req_in_mask_i[w_gnt];
    w_wr.data   = req_in_data_i[w_gnt];
    w_wr.source = w_wr_src;
  end

  assign req_out_valid_o = (r_fcnt != '0);
  assign w_rd            = req_out_valid_o & req_out_ready_i;

  // FIFO pointers/occupancy; a full FIFO refuses writes even while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_acc) r_wp <= (r_wp == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_rd)  r_rp <= (r_rp == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_fcnt <= r_fcnt + FCNT_W'(w_acc) - FCNT_W'(w_rd);
    end
  end

  // FIFO storage; payload needs no reset since occupancy gates it.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wp] <= w_wr;
  end

  assign w_rd_ent         = r_mem[r_rp];
  assign req_out_opcode_o = w_rd_ent.opcode;
  assign req_out_param_o  = w_rd_ent.param;
  assign req_out_addr_o   = w_rd_ent.addr;
  assign req_out_mask_o   = w_rd_ent.mask;
  assign req_out_data_o   = w_rd_ent.data;
  assign req_out_source_o = w_rd_ent.source;

  // Misrouted responses are swallowed; otherwise backpressure comes from the target SM.
  always_comb begin
    rsp_in_ready_o = 1'b1;
    if (!w_bad) rsp_in_ready_o = rsp_out_ready_i[w_rk];
  end

  // Sticky flag for any response whose index prefix names no input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_err <= 1'b0;
    else if (rsp_in_valid_i && w_bad) r_err <= 1'b1;
  end
  assign err_o = r_err;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    logic w_hit, w_inc, w_dec;
    assign w_hit               = ~w_bad & (w_rk == PTR_W'(i));
    assign w_inc               = w_acc & (w_gnt == PTR_W'(i));
    assign w_dec               = rsp_in_valid_i & w_hit & rsp_out_ready_i[i];
    assign rsp_out_valid_o[i]  = rsp_in_valid_i & w_hit;
    assign rsp_out_opcode_o[i] = rsp_in_opcode_i;
    assign rsp_out_addr_o[i]   = rsp_in_addr_i;
    assign rsp_out_data_o[i]   = rsp_in_data_i;
    assign rsp_out_source_o[i] = rsp_in_source_i[SRC_W-1:0];

    sm2cluster_outst_cnt #(
      .MAX_OUTST(MAX_OUTST),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_inc  (w_inc),
      .i_dec  (w_dec),
      .o_avail(w_avail[i])
    );
  end
endmodule
